// File: rtl/serial_subtractor.sv
`default_nettype none

// ============================================================================
// Module      : full_adder_cell
// Description : One-bit full adder. This is the single arithmetic cell that
//               the serial subtractor reuses on every bit.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    // Sum and majority carry of the three input bits
    assign o_sum   = i_x ^ i_y ^ i_cin;
    assign o_carry = (i_x & i_y) | (i_x & i_cin) | (i_y & i_cin);

endmodule

// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor. Computes a - b one
//               bit per clock, LSB first, as a + ~b + 1 through a single
//               full-adder cell. A start/busy/done handshake connects it to
//               the controlling FSM. diff, borrow_out and overflow are
//               registered and held until the next completed operation.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    // Bit counter width; it only has to reach WIDTH-1
    localparam int unsigned          c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;      // minuend, shifted right each bit
    logic [WIDTH-1:0]   r_sb;      // inverted subtrahend, shifted right each bit
    logic [WIDTH-1:0]   r_res;     // result bits enter at the MSB
    logic               r_carry;   // carry into the bit being processed
    logic [c_CNT_W-1:0] r_count;   // index of the bit being processed

    logic               w_sum;
    logic               w_carry_out;
    logic [WIDTH-1:0]   w_res_next;

    // Single shared adder cell: the +1 of the two's complement comes from
    // seeding the carry with 1 at capture time
    full_adder_cell u_fa (
        .i_x     (r_sa[0]),
        .i_y     (r_sb[0]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_carry_out)
    );

    // Result register as it will look after this bit has been shifted in
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= ~b;
                        r_carry <= 1'b1;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
                    r_res   <= w_res_next;
                    r_carry <= w_carry_out;
                    if (r_count == c_LAST) begin
                        // r_carry still holds the carry into the MSB here,
                        // so overflow is carry-in XOR carry-out of the MSB
                        r_count    <= '0;
                        diff       <= w_res_next;
                        borrow_out <= ~w_carry_out;
                        overflow   <= r_carry ^ w_carry_out;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_DONE: begin
                    // start is deliberately not sampled here
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The bit counter stays within the operand width
    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_LAST);

    // A done pulse is always accompanied by busy
    a_done_busy : assert property (@(posedge clk) disable iff (!rst_n)
        done |-> busy);
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none

// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor. Drives an 8-bit and
//               a 4-bit instance; expected results come from plain integer
//               arithmetic on the operands at capture time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bo4, ov4;
    logic [3:0] diff4;

    int checks   = 0;
    int failures = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;

    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .overflow   (ov8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bo4),
        .overflow   (ov4)
    );

    // Reference: unsigned wrap difference, unsigned borrow, signed range test
    function automatic exp_t ref_sub(input int w, input int av, input int bv);
        exp_t r;
        int   full = 1 << w;
        int   half = 1 << (w - 1);
        int   sa   = (av >= half) ? av - full : av;
        int   sb   = (bv >= half) ? bv - full : bv;
        int   s    = sa - sb;
        r.d  = 8'((av - bv + full) % full);
        r.bo = (av < bv);
        r.ov = (s > half - 1) || (s < -half);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            exp_t e;
            done8_cnt++;
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op");
            end else begin
                e = q8.pop_front();
                chk("diff8", 32'(diff8), 32'(e.d));
                chk("borrow8", 32'(bo8), 32'(e.bo));
                chk("overflow8", 32'(ov8), 32'(e.ov));
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            exp_t e;
            done4_cnt++;
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done4_unexpected: got done=1 expected no pending op");
            end else begin
                e = q4.pop_front();
                chk("diff4", 32'(diff4), 32'(e.d[3:0]));
                chk("borrow4", 32'(bo4), 32'(e.bo));
                chk("overflow4", 32'(ov4), 32'(e.ov));
            end
        end
    end

    task automatic wait_idle8();
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy8 === 1'b0) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("wait_idle8_timeout", 32'(busy8), 32'(0));
    endtask

    // One operation with latency, post-done idle and result-hold checks
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int   lat  = 0;
        bit   seen = 0;
        wait_idle8();
        e = ref_sub(8, int'(av), int'(bv));
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        q8.push_back(e);
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick();
            if (done8 === 1'b1) begin
                seen = 1;
                lat = i;
            end
        end
        chk("latency8", 32'(lat), 32'(8));
        tick();
        chk("busy_after_done8", 32'(busy8), 32'(0));
        repeat (2) tick();
        chk("diff_hold8", 32'(diff8), 32'(e.d));
    endtask

    initial begin
        exp_t e;
        int   dn;
        int   cnt0;

        rst_n  = 1'b0;
        start8 = 1'b1;
        start4 = 1'b1;
        a8 = 8'h12; b8 = 8'h34;
        a4 = 4'h1;  b4 = 4'h2;
        repeat (3) tick();
        chk("reset_busy8", 32'(busy8), 32'(0));
        chk("reset_done8", 32'(done8), 32'(0));
        chk("reset_diff8", 32'(diff8), 32'(0));
        chk("reset_borrow8", 32'(bo8), 32'(0));
        chk("reset_overflow8", 32'(ov8), 32'(0));
        chk("reset_busy4", 32'(busy4), 32'(0));
        rst_n  = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        tick();
        chk("idle_after_reset8", 32'(busy8), 32'(0));

        // Directed cases
        issue8(8'h05, 8'h03);
        issue8(8'h03, 8'h05);
        issue8(8'h80, 8'h01);
        issue8(8'h00, 8'hFF);
        issue8(8'h5A, 8'h5A);
        issue8(8'h7F, 8'hFF);
        issue8(8'hFF, 8'h00);

        // Random operands
        for (int n = 0; n < 40; n++) issue8(8'($urandom), 8'($urandom));

        // start held high, operands disturbed mid-RUN
        wait_idle8();
        start8 = 1'b1;
        for (int op = 0; op < 4; op++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            q8.push_back(ref_sub(8, int'(a8), int'(b8)));
            tick();
            dn = 0;
            for (int j = 1; j <= 9; j++) begin
                if (j == 3) begin
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                end
                tick();
                if (done8 === 1'b1) dn++;
            end
            chk("done_per_window8", 32'(dn), 32'(1));
        end
        start8 = 1'b0;
        tick();

        // Reset in the middle of RUN
        wait_idle8();
        a8 = 8'h33;
        b8 = 8'h11;
        start8 = 1'b1;
        q8.push_back(ref_sub(8, 'h33, 'h11));
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst_n  = 1'b0;
        start8 = 1'b1;
        tick();
        rst_n  = 1'b1;
        start8 = 1'b0;
        void'(q8.pop_back());
        chk("abort_busy8", 32'(busy8), 32'(0));
        chk("abort_done8", 32'(done8), 32'(0));
        chk("abort_diff8", 32'(diff8), 32'(0));
        chk("abort_borrow8", 32'(bo8), 32'(0));
        chk("abort_overflow8", 32'(ov8), 32'(0));
        cnt0 = done8_cnt;
        repeat (12) tick();
        chk("no_done_after_abort8", 32'(done8_cnt - cnt0), 32'(0));
        issue8(8'h40, 8'hC0);

        // Exhaustive sweep on the 4-bit instance
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                a4 = 4'(av);
                b4 = 4'(bv);
                start4 = 1'b1;
                q4.push_back(ref_sub(4, av, bv));
                tick();
                start4 = 1'b0;
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                repeat (5) tick();
            end
        end
        repeat (3) tick();
        chk("done4_count", 32'(done4_cnt), 32'(256));
        chk("q4_drained", 32'(q4.size()), 32'(0));
        chk("q8_drained", 32'(q8.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
